oddr_test_core: RTL and testbench
=================================

Name:
oddr_test_core

Overview:
- DDR output-register test block: drives a repeating serial bit pattern on one output pin at two bits per clock, one bit in each clock phase.
- Exercises the FPGA output DDR (ODDR) path from a single fabric clock.
- Instantiated as `oddr_test_wrapper` in the ODDR test top level; `module_output` goes straight to a pad.

Parameters:
- PATTERN, 8'hB4, fixed pattern word, shifted out MSB first.
- PATTERN_W, 8, pattern width in bits; must be even, range 2..32.
- USE_PRIMITIVE, 0: 0 = behavioural ODDR model; 1 = vendor ODDR primitive in SAME_EDGE mode. Pin behaviour is identical in both cases.

Ports:
- clk  input  1  fabric clock, 100 MHz nominal; all logic on rising edge except the falling-phase ODDR stage.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  synchronous run control; high = transmit pattern.
- module_output  output  1  DDR serial data to pad.

Interface (already decided):
- One clock. Reset is synchronous and active-low.

Behaviour:
- **Stages:** enable register `en_q` -> pattern pointer / pair select -> ODDR capture registers `d_hi`, `d_lo` -> pin.
- **Reset:** rst_n is sampled low at a rising edge. That edge clears `en_q`, the pointer, `d_hi` and `d_lo`. The falling-phase register clears on the next falling edge. module_output = 0 throughout reset.
- **Enable register:** `en_q` <= enable at each rising edge.
- **Pointer behaviour:**
  - While `en_q` = 0: pointer held at 0 and `d_hi` / `d_lo` <= 0.
  - While `en_q` = 1: at each rising edge, `d_hi` <= PATTERN[PATTERN_W-1-2p] and `d_lo` <= PATTERN[PATTERN_W-2-2p], where p is the pointer.
  - Pointer then increments and wraps from PATTERN_W/2-1 to 0.
- **Pin output:**
  - `d_hi` drives the pin during the high phase following the capturing rising edge.
  - `d_lo` drives the pin during the subsequent low phase.
  - The behavioural model re-times `d_lo` to the falling edge, then muxes between the two values on clk level.
- **Start latency:** enable sampled high at rising edge k -> pair 0 (MSB, MSB-1) appears in the clock period that starts at edge k+1. The word repeats every PATTERN_W/2 cycles with no gap.
- **Stop:**
  - Enable sampled low at edge m -> pin = 0 from edge m+1.
  - Deasserting mid-word aborts the word; there is no completion.
  - Re-enabling always restarts at the MSB.
- **Enable glitches:** a one-cycle enable pulse produces exactly one pair (MSB, MSB-1).
- **Reset priority:** reset has priority over enable. Releasing reset while enable = 1 gives the same start latency as a rising enable.
- **Idle level:** the pin never toggles when idle; it stays at 0.

Optional Feature:
- Macro: ODDR_PRBS_EN.
- **Defined:**
  - The pattern source is PRBS7, polynomial x^7+x^6+1, 7-bit Fibonacci LFSR, seed 7'h7F.
  - Output bit is lfsr[6]; feedback lfsr[6]^lfsr[5] is shifted into the LSB.
  - The LFSR advances two steps per enabled cycle: first bit -> `d_hi`, second bit -> `d_lo`.
  - It reloads the seed whenever `en_q` = 0 or in reset.
  - The PATTERN parameter is ignored.
- **Undefined:** fixed PATTERN source as described above. No LFSR logic is synthesised.

Test Plan:
- **Reset:** rst_n = 0 for 2 cycles with enable = 0, then 1 -> module_output constant 0; no transitions.
- **Fixed pattern:** enable = 1 at edge k, PATTERN = 8'hB4 -> from edge k+1 the pin shows (hi, lo) = (1,0), (1,1), (0,1), (0,0), repeating every 4 cycles for 100 cycles, checked at mid-high and mid-low of each period.
- **Stop and restart:**
  - Deassert enable after 5 cycles (mid-word) -> pin = 0 one cycle later.
  - Re-enable -> restarts at (1,0).
- **Single pulse:** 1-cycle enable pulse -> exactly one period with (1,0), then 0.
- **Reset mid-run:** rst_n = 0 while enabled -> pin = 0 from the following period. Release with enable = 1 -> (1,0) starts one cycle after the release edge.
- **ODDR_PRBS_EN defined:** enable -> first 7 bits are all 1, the 8th bit is 0. Bits alternate hi/lo phase. The sequence matches the reference LFSR for 254 bits (2×127 period).

Source files
------------

// File: rtl/oddr_test_core.sv
// -----------------------------------------------------------------------------
// oddr_test_core
//
// DDR output-register test block. Sends a repeating serial bit pattern on one
// pad at two bits per fabric clock: the first bit of each pair is driven while
// clk is high, the second while clk is low.
//
// Pipeline: enable register en_q -> pattern pointer / pair select ->
// ODDR capture registers d_hi / d_lo -> DDR output stage -> pin.
//
// Parameters:
//   PATTERN_W      pattern width in bits, even, 2..32
//   PATTERN        fixed pattern word, shifted out MSB first
//   USE_PRIMITIVE  0 = behavioural ODDR stage, 1 = SAME_EDGE-style ODDR cell;
//                  pin behaviour is identical
//
// Optional build macro:
//   ODDR_PRBS_EN   when defined, the pattern source is a PRBS7 LFSR
//                  (x^7+x^6+1, seed 7'h7F, two bits per cycle) and PATTERN is
//                  ignored; when undefined no LFSR logic exists.
//
// Ports:
//   clk            fabric clock (rising edge, plus the falling-phase stage)
//   rst_n          synchronous active-low reset
//   enable         synchronous run control, high = transmit
//   module_output  DDR serial data to pad
// -----------------------------------------------------------------------------
module oddr_test_core #(
  parameter int                   PATTERN_W     = 8,
  parameter logic [PATTERN_W-1:0] PATTERN       = 8'hB4,
  parameter bit                   USE_PRIMITIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic module_output
);

  // ---------------------------------------------------------------------------
  // Enable register
  // ---------------------------------------------------------------------------
  logic en_d, en_q;

  always_comb begin
    en_d = enable;
  end

  // ---------------------------------------------------------------------------
  // Pattern source: produces the next (hi, lo) pair while en_q is high
  // ---------------------------------------------------------------------------
  logic d_hi_d, d_hi_q;
  logic d_lo_d, d_lo_q;

`ifdef ODDR_PRBS_EN
  localparam logic [6:0] LFSR_SEED = 7'h7F;

  logic [6:0] lfsr_d, lfsr_q;
  logic [6:0] lfsr_mid;

  // Two Fibonacci steps per enabled cycle: lfsr[6] is the output bit and
  // lfsr[6]^lfsr[5] enters at the LSB. Any idle cycle reloads the seed so
  // every run starts from the same point of the sequence.
  always_comb begin
    lfsr_mid = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    d_hi_d   = 1'b0;
    d_lo_d   = 1'b0;
    lfsr_d   = LFSR_SEED;
    if (en_q) begin
      d_hi_d = lfsr_q[6];
      d_lo_d = lfsr_mid[6];
      lfsr_d = {lfsr_mid[5:0], lfsr_mid[6] ^ lfsr_mid[5]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  localparam int IDX_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 2;
  localparam int PTR_W = IDX_W - 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PATTERN_W / 2 - 1);

  logic [PTR_W-1:0] ptr_d, ptr_q;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    // Pair p occupies bits (W-1-2p, W-2-2p), so the MSB goes out first.
    hi_idx = IDX_W'(PATTERN_W - 1) - {ptr_q, 1'b0};
    lo_idx = hi_idx - IDX_W'(1);
    d_hi_d = 1'b0;
    d_lo_d = 1'b0;
    ptr_d  = '0;
    if (en_q) begin
      d_hi_d = PATTERN[hi_idx];
      d_lo_d = PATTERN[lo_idx];
      ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      d_hi_q <= 1'b0;
      d_lo_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      d_hi_q <= d_hi_d;
      d_lo_q <= d_lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // DDR output stage. d_hi_q is shown during the high phase right after the
  // capturing edge; d_lo_q is moved to the falling edge so it is stable for
  // the whole low phase, then the two are selected on clk level.
  // ---------------------------------------------------------------------------
  generate
    if (USE_PRIMITIVE) begin : g_same_edge
      // SAME_EDGE-style cell: both bits were presented on the same rising
      // edge; only the low-phase bit needs the internal falling-edge retime.
      logic d2_neg_q;

      always_ff @(negedge clk) begin
        if (!rst_n) begin
          d2_neg_q <= 1'b0;
        end else begin
          d2_neg_q <= d_lo_q;
        end
      end

      assign module_output = clk ? d_hi_q : d2_neg_q;
    end else begin : g_behav
      logic d_lo_neg_d, d_lo_neg_q;

      always_comb begin
        d_lo_neg_d = d_lo_q;
      end

      // Synchronous reset on the falling stage as well: it clears on the
      // first falling edge that sees rst_n low.
      always_ff @(negedge clk) begin
        if (!rst_n) begin
          d_lo_neg_q <= 1'b0;
        end else begin
          d_lo_neg_q <= d_lo_neg_d;
        end
      end

      assign module_output = clk ? d_hi_q : d_lo_neg_q;
    end
  endgenerate

endmodule

// File: tb/tb_oddr_test_core.sv
// -----------------------------------------------------------------------------
// tb_oddr_test_core
//
// Directed bench for oddr_test_core. Each clock period is sampled twice,
// 2 ns into the high phase and 2 ns into the low phase, and the pair
// {hi, lo} is compared against hand-derived values for PATTERN = 8'hB4:
// pairs (1,0), (1,1), (0,1), (0,0). With ODDR_PRBS_EN defined the pattern
// checks are replaced by a PRBS7 reference sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oddr_test_core;

  logic clk;
  logic rst_n;
  logic enable;
  logic module_output;

  int total;
  int bad;

  // Hand-derived pair sequence for 8'hB4 = 1011_0100, MSB first.
  logic [1:0] exp_pairs [4];

  oddr_test_core #(
    .PATTERN_W    (8),
    .PATTERN      (8'hB4),
    .USE_PRIMITIVE(1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .module_output(module_output)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Samples the clock period that starts at the next rising edge.
  // Returns with time 2 ns into the low phase, well away from any edge.
  task automatic sample_period(output logic [1:0] pair);
    @(posedge clk);
    #2;
    pair[1] = module_output;
    @(negedge clk);
    #2;
    pair[0] = module_output;
  endtask

  // Drops enable and lets the pipeline drain; no checks here.
  task automatic go_idle();
    logic [1:0] p;
    enable = 1'b0;
    sample_period(p);
    sample_period(p);
  endtask

  task automatic test_reset();
    logic [1:0] p;
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample_period(p);
      total++;
      if (p !== 2'b00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %b want 00", i, p);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_period(p);
      total++;
      if (p !== 2'b00) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got %b want 00", i, p);
      end
    end
  endtask

`ifndef ODDR_PRBS_EN
  task automatic test_fixed_pattern();
    logic [1:0] p;
    go_idle();
    enable = 1'b1;
    // Period starting at the edge that samples enable is still idle.
    sample_period(p);
    total++;
    if (p !== 2'b00) begin
      bad++;
      $display("FAIL pattern_latency: got %b want 00", p);
    end
    for (int i = 0; i < 100; i++) begin
      sample_period(p);
      total++;
      if (p !== exp_pairs[i % 4]) begin
        bad++;
        $display("FAIL pattern[%0d]: got %b want %b", i, p, exp_pairs[i % 4]);
      end
    end
  endtask

  task automatic test_stop_restart();
    logic [1:0] p;
    go_idle();
    enable = 1'b1;
    sample_period(p);
    for (int i = 0; i < 5; i++) begin
      sample_period(p);
      total++;
      if (p !== exp_pairs[i % 4]) begin
        bad++;
        $display("FAIL stop_run[%0d]: got %b want %b", i, p, exp_pairs[i % 4]);
      end
    end
    // Mid-word stop: the pair already captured on the sampling edge still
    // goes out, then the pin is 0.
    enable = 1'b0;
    sample_period(p);
    total++;
    if (p !== exp_pairs[1]) begin
      bad++;
      $display("FAIL stop_last: got %b want %b", p, exp_pairs[1]);
    end
    for (int i = 0; i < 3; i++) begin
      sample_period(p);
      total++;
      if (p !== 2'b00) begin
        bad++;
        $display("FAIL stop_zero[%0d]: got %b want 00", i, p);
      end
    end
    enable = 1'b1;
    sample_period(p);
    total++;
    if (p !== 2'b00) begin
      bad++;
      $display("FAIL restart_latency: got %b want 00", p);
    end
    for (int i = 0; i < 2; i++) begin
      sample_period(p);
      total++;
      if (p !== exp_pairs[i]) begin
        bad++;
        $display("FAIL restart[%0d]: got %b want %b", i, p, exp_pairs[i]);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [1:0] p;
    go_idle();
    enable = 1'b1;
    sample_period(p);
    enable = 1'b0;
    sample_period(p);
    total++;
    if (p !== 2'b10) begin
      bad++;
      $display("FAIL pulse_pair: got %b want 10", p);
    end
    for (int i = 0; i < 4; i++) begin
      sample_period(p);
      total++;
      if (p !== 2'b00) begin
        bad++;
        $display("FAIL pulse_after[%0d]: got %b want 00", i, p);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] p;
    go_idle();
    enable = 1'b1;
    sample_period(p);
    for (int i = 0; i < 3; i++) begin
      sample_period(p);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_period(p);
      total++;
      if (p !== 2'b00) begin
        bad++;
        $display("FAIL midrst_hold[%0d]: got %b want 00", i, p);
      end
    end
    // Release with enable still high: same latency as a rising enable.
    rst_n = 1'b1;
    sample_period(p);
    total++;
    if (p !== 2'b00) begin
      bad++;
      $display("FAIL midrst_latency: got %b want 00", p);
    end
    for (int i = 0; i < 4; i++) begin
      sample_period(p);
      total++;
      if (p !== exp_pairs[i]) begin
        bad++;
        $display("FAIL midrst_run[%0d]: got %b want %b", i, p, exp_pairs[i]);
      end
    end
  endtask
`else
  task automatic test_prbs();
    logic [1:0] p;
    logic [1:0] exp;
    logic [6:0] ref_lfsr;
    go_idle();
    ref_lfsr = 7'h7F;
    enable = 1'b1;
    sample_period(p);
    total++;
    if (p !== 2'b00) begin
      bad++;
      $display("FAIL prbs_latency: got %b want 00", p);
    end
    // 127 periods = 254 bits = two full PRBS7 periods.
    for (int i = 0; i < 127; i++) begin
      exp[1]   = ref_lfsr[6];
      ref_lfsr = {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
      exp[0]   = ref_lfsr[6];
      ref_lfsr = {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
      sample_period(p);
      total++;
      if (p !== exp) begin
        bad++;
        $display("FAIL prbs[%0d]: got %b want %b", i, p, exp);
      end
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    exp_pairs[0] = 2'b10;
    exp_pairs[1] = 2'b11;
    exp_pairs[2] = 2'b01;
    exp_pairs[3] = 2'b00;

    test_reset();
`ifndef ODDR_PRBS_EN
    test_fixed_pattern();
    test_stop_restart();
    test_single_pulse();
    test_reset_mid_run();
`else
    test_prbs();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
